// File: rtl/syn_fft_pkg.sv
// Shared FFT types and helpers.
//   fft_sample_t    : one complex result, {re, im}, 32-bit signed each (re in the MSBs).
//   fgyrus_mode_t   : engine operating mode; NORMAL runs, CONFIG holds everything idle.
//   fft_rdr_state_t : result reader FSM states.
//   bit_rev()       : reverses the low 'width' bits of a value (width <= 32).
package syn_fft_pkg;

  localparam int unsigned P_FFT_NUM_SAMPLES = 128;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } fft_sample_t;

  typedef enum logic {
    FGYRUS_NORMAL = 1'b0,
    FGYRUS_CONFIG = 1'b1
  } fgyrus_mode_t;

  typedef enum logic [1:0] {
    RDR_IDLE,
    RDR_READ,
    RDR_DRAIN
  } fft_rdr_state_t;

  function automatic logic [31:0] bit_rev(input logic [31:0] val, input int unsigned width);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) res[i] = val[width - 1 - i];
    end
    return res;
  endfunction

endpackage

// File: rtl/syn_fft_res_rdr_fifo.sv
// Synchronous first-word-fall-through FIFO for the result reader.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_data  : write strobe and word ({idx, fft_sample_t})
//   i_pop           : consume the head word (o_data is valid whenever !o_empty)
//   i_flush         : drop all contents this cycle (dominates push/pop)
//   o_data          : head word
//   o_count         : number of stored words
//   o_empty, o_full : status
module syn_fft_res_rdr_fifo #(
  parameter int unsigned P_WIDTH = 71,
  parameter int unsigned P_DEPTH = 4,
  localparam int unsigned LP_PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
  localparam int unsigned LP_CNT_W = $clog2(P_DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [P_WIDTH-1:0]  i_data,
  input  logic                i_pop,
  input  logic                i_flush,
  output logic [P_WIDTH-1:0]  o_data,
  output logic [LP_CNT_W-1:0] o_count,
  output logic                o_empty,
  output logic                o_full
);

  logic [P_WIDTH-1:0]  r_mem [P_DEPTH];
  logic [LP_PTR_W-1:0] r_wr_ptr;
  logic [LP_PTR_W-1:0] r_rd_ptr;
  logic [LP_CNT_W-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [LP_PTR_W-1:0] ptr_inc(input logic [LP_PTR_W-1:0] p);
    return (p == LP_PTR_W'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LP_CNT_W'(P_DEPTH));

endmodule

// File: rtl/syn_fft_res_rdr.sv
// FFT result reader: after fft_done_i, reads P_NUM_SAMPLES results from the result RAM
// (fixed read latency P_RD_LAT) and streams them out over valid/ready. Reads are only
// issued when the output FIFO has room for every read still in flight, so backpressure
// never drops a sample.
// Ports:
//   clk_ir, rst_ih            : clock, synchronous active-high reset
//   fgyrus_mode_i             : NORMAL enables reading; CONFIG aborts / blocks it
//   fft_done_i                : frame-ready pulse
//   ram_rd_en_o/ram_rd_addr_o : RAM read port request
//   ram_rd_data_i             : RAM data, valid P_RD_LAT cycles after ram_rd_en_o
//   smpl_valid_o/smpl_ready_i : output handshake
//   smpl_o, smpl_idx_o        : sample and its natural bin index
//   smpl_last_o               : final sample of the frame
//   busy_o                    : frame read in progress
//   ovrn_o                    : sticky, fft_done_i seen while busy
// Build option: define SYN_FFT_RES_RDR_BIT_REV_EN to address the RAM in bit-reversed
// order (natural-order output from an in-place radix-2 engine).
module syn_fft_res_rdr
  import syn_fft_pkg::*;
#(
  parameter int unsigned P_NUM_SAMPLES = P_FFT_NUM_SAMPLES,
  parameter int unsigned P_RAM_ADDR_W  = 7,
  parameter int unsigned P_RD_LAT      = 2,
  parameter int unsigned P_FIFO_DEPTH  = 4
) (
  input  logic                    clk_ir,
  input  logic                    rst_ih,
  input  fgyrus_mode_t            fgyrus_mode_i,
  input  logic                    fft_done_i,
  output logic                    ram_rd_en_o,
  output logic [P_RAM_ADDR_W-1:0] ram_rd_addr_o,
  input  fft_sample_t             ram_rd_data_i,
  output logic                    smpl_valid_o,
  input  logic                    smpl_ready_i,
  output fft_sample_t             smpl_o,
  output logic [P_RAM_ADDR_W-1:0] smpl_idx_o,
  output logic                    smpl_last_o,
  output logic                    busy_o,
  output logic                    ovrn_o
);

  localparam int unsigned LP_SMPL_W = $bits(fft_sample_t);
  localparam int unsigned LP_FIFO_W = P_RAM_ADDR_W + LP_SMPL_W;
  localparam int unsigned LP_FCNT_W = $clog2(P_FIFO_DEPTH + 1);
  localparam int unsigned LP_CRD_W  = $clog2(P_FIFO_DEPTH + P_RD_LAT + 1);
  localparam logic [P_RAM_ADDR_W-1:0] LP_LAST_IDX = P_RAM_ADDR_W'(P_NUM_SAMPLES - 1);

  fft_rdr_state_t          r_state;
  fft_rdr_state_t          w_state_nxt;
  logic [P_RAM_ADDR_W-1:0] r_rd_cnt;
  logic [P_RD_LAT-1:0]     r_pipe_vld;
  logic [P_RAM_ADDR_W-1:0] r_pipe_idx [P_RD_LAT];
  logic                    r_ovrn;

  logic                    w_rd_en;
  logic [P_RAM_ADDR_W-1:0] w_rd_addr;
  logic                    w_abort;
  logic                    w_pop;
  logic                    w_credit_ok;
  logic [LP_CRD_W-1:0]     w_in_flight;
  logic [LP_FIFO_W-1:0]    w_fifo_rdata;
  logic [LP_FCNT_W-1:0]    w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [P_RAM_ADDR_W-1:0] w_head_idx;

  assign w_abort = (r_state != RDR_IDLE) && (fgyrus_mode_i == FGYRUS_CONFIG);
  assign w_pop   = smpl_valid_o && smpl_ready_i;

  always_comb begin
    w_in_flight = '0;
    for (int unsigned i = 0; i < P_RD_LAT; i++) begin
      w_in_flight = w_in_flight + LP_CRD_W'(r_pipe_vld[i]);
    end
  end

  // A read is only issued if its data is guaranteed a FIFO slot on return.
  assign w_credit_ok = !w_fifo_full &&
                       ((LP_CRD_W'(w_fifo_count) + w_in_flight) < LP_CRD_W'(P_FIFO_DEPTH));

`ifdef SYN_FFT_RES_RDR_BIT_REV_EN
  assign w_rd_addr = P_RAM_ADDR_W'(bit_rev(32'(r_rd_cnt), P_RAM_ADDR_W));
`else
  assign w_rd_addr = r_rd_cnt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    unique case (r_state)
      RDR_IDLE: begin
        if (fft_done_i && (fgyrus_mode_i == FGYRUS_NORMAL)) w_state_nxt = RDR_READ;
      end
      RDR_READ: begin
        if (w_abort) begin
          w_state_nxt = RDR_IDLE;
        end else if (w_credit_ok) begin
          w_rd_en = 1'b1;
          if (r_rd_cnt == LP_LAST_IDX) w_state_nxt = RDR_DRAIN;
        end
      end
      RDR_DRAIN: begin
        // The last index is the final FIFO entry, so its handshake empties everything.
        if (w_abort || (w_pop && smpl_last_o && (w_in_flight == '0))) w_state_nxt = RDR_IDLE;
      end
      default: w_state_nxt = RDR_IDLE;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      r_state    <= RDR_IDLE;
      r_rd_cnt   <= '0;
      r_pipe_vld <= '0;
      r_ovrn     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == RDR_IDLE) && (w_state_nxt == RDR_READ)) begin
        r_rd_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      for (int unsigned i = P_RD_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
      r_pipe_vld[0] <= w_rd_en;
      if (w_abort) r_pipe_vld <= '0;
      if (fgyrus_mode_i == FGYRUS_CONFIG) begin
        r_ovrn <= 1'b0;
      end else if (fft_done_i && (r_state != RDR_IDLE)) begin
        r_ovrn <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ir) begin
    for (int unsigned i = P_RD_LAT - 1; i > 0; i--) begin
      r_pipe_idx[i] <= r_pipe_idx[i-1];
    end
    r_pipe_idx[0] <= r_rd_cnt;
  end

  syn_fft_res_rdr_fifo #(
    .P_WIDTH (LP_FIFO_W),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_ir),
    .i_rst   (rst_ih),
    .i_push  (r_pipe_vld[P_RD_LAT-1]),
    .i_data  ({r_pipe_idx[P_RD_LAT-1], ram_rd_data_i}),
    .i_pop   (w_pop),
    .i_flush (w_abort),
    .o_data  (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_head_idx    = w_fifo_rdata[LP_FIFO_W-1 -: P_RAM_ADDR_W];
  assign smpl_valid_o  = !w_fifo_empty;
  // Gate the head so the outputs read zero rather than stale RAM contents when idle.
  assign smpl_o        = smpl_valid_o ? fft_sample_t'(w_fifo_rdata[LP_SMPL_W-1:0]) : '0;
  assign smpl_idx_o    = smpl_valid_o ? w_head_idx : '0;
  assign smpl_last_o   = smpl_valid_o && (w_head_idx == LP_LAST_IDX);
  assign busy_o        = (r_state != RDR_IDLE);
  assign ovrn_o        = r_ovrn;
  assign ram_rd_en_o   = w_rd_en;
  assign ram_rd_addr_o = w_rd_en ? w_rd_addr : '0;

endmodule

// File: tb/tb_syn_fft_res_rdr.sv
// Self-checking bench for syn_fft_res_rdr: RAM model with 2-cycle latency, transaction
// scoreboard checked every cycle, plus directed frames (streaming, backpressure, overrun,
// abort, reset in drain, random frames).
module tb_syn_fft_res_rdr;
  import syn_fft_pkg::*;

  localparam int NS    = 128;
  localparam int DEPTH = 4;
`ifdef SYN_FFT_RES_RDR_BIT_REV_EN
  localparam int EXP_A1 = 64;
  localparam int EXP_A2 = 32;
`else
  localparam int EXP_A1 = 1;
  localparam int EXP_A2 = 2;
`endif

  logic         clk;
  logic         rst;
  fgyrus_mode_t mode;
  logic         fft_done;
  logic         ram_rd_en;
  logic [6:0]   ram_rd_addr;
  fft_sample_t  ram_rd_data;
  logic         smpl_valid;
  logic         ready;
  fft_sample_t  smpl;
  logic [6:0]   smpl_idx;
  logic         smpl_last;
  logic         busy;
  logic         ovrn;

  syn_fft_res_rdr u_dut (
    .clk_ir        (clk),
    .rst_ih        (rst),
    .fgyrus_mode_i (mode),
    .fft_done_i    (fft_done),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data),
    .smpl_valid_o  (smpl_valid),
    .smpl_ready_i  (ready),
    .smpl_o        (smpl),
    .smpl_idx_o    (smpl_idx),
    .smpl_last_o   (smpl_last),
    .busy_o        (busy),
    .ovrn_o        (ovrn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int n);
`ifdef SYN_FFT_RES_RDR_BIT_REV_EN
    int r;
    r = 0;
    for (int b = 0; b < 7; b++) r = r * 2 + ((n >> b) & 1);
    return r;
`else
    return n;
`endif
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: request seen in cycle t returns data during cycle t+2, junk otherwise.
  fft_sample_t mem [NS];
  logic        s_rd_en;
  logic [6:0]  s_rd_addr;
  logic [1:0]  lat_vld = '0;
  logic [6:0]  lat_addr [2];
  fft_sample_t junk;

  always @(negedge clk) begin
    s_rd_en   = ram_rd_en;
    s_rd_addr = ram_rd_addr;
  end

  always @(posedge clk) begin
    lat_vld[0]  <= s_rd_en;
    lat_vld[1]  <= lat_vld[0];
    lat_addr[0] <= s_rd_addr;
    lat_addr[1] <= lat_addr[0];
    junk        <= {$urandom, $urandom};
  end

  assign ram_rd_data = lat_vld[1] ? mem[lat_addr[1]] : junk;

  // Downstream ready: scripted value or random 30% duty.
  logic bp_en     = 1'b0;
  logic ready_cmd = 1'b1;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = bp_en ? ($urandom_range(0, 99) < 30) : ready_cmd;
    end
  end

  // Scoreboard state: frame progress in terms of reads issued and samples delivered.
  logic        mon_en     = 1'b0;
  logic        m_busy     = 1'b0;
  logic        m_ovrn     = 1'b0;
  int          m_next_idx = 0;
  int          m_next_rd  = 0;
  int          m_out      = 0;
  logic        m_stall    = 1'b0;
  logic [6:0]  m_stall_idx;
  fft_sample_t m_stall_data;
  int          n_hs       = 0;
  logic        saw_last   = 1'b0;
  int          addr_log [4];

  always @(negedge clk) begin
    logic hs;
    logic was_busy;
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("ovrn", ovrn, m_ovrn);
      if (ram_rd_en) begin
        chk("rd_in_frame", m_busy && (m_next_rd < NS), 1);
        chk("rd_addr", ram_rd_addr, addr_of(m_next_rd));
        chk("credit", (m_out + 1) <= DEPTH, 1);
        if (m_next_rd < 4) addr_log[m_next_rd] = int'(ram_rd_addr);
      end
      if (m_stall) begin
        chk("stall_valid", smpl_valid, 1);
        chk("stall_idx", smpl_idx, m_stall_idx);
        chk("stall_data", smpl, m_stall_data);
      end
      if (smpl_valid) begin
        chk("valid_in_frame", m_busy, 1);
        chk("idx", smpl_idx, m_next_idx);
        chk("data", smpl, mem[addr_of(m_next_idx & (NS - 1))]);
        chk("last", smpl_last, m_next_idx == NS - 1);
      end else begin
        chk("last_no_valid", smpl_last, 0);
      end

      hs = smpl_valid && ready;
      if (hs) begin
        n_hs++;
        if (smpl_last) saw_last = 1'b1;
      end
      m_stall      = smpl_valid && !ready;
      m_stall_idx  = smpl_idx;
      m_stall_data = smpl;
      was_busy     = m_busy;
      if (rst) begin
        m_busy  = 1'b0;
        m_ovrn  = 1'b0;
        m_stall = 1'b0;
      end else if (m_busy && mode == FGYRUS_CONFIG) begin
        m_busy  = 1'b0;
        m_ovrn  = 1'b0;
        m_stall = 1'b0;
      end else begin
        if (mode == FGYRUS_CONFIG) m_ovrn = 1'b0;
        if (fft_done && was_busy) m_ovrn = 1'b1;
        if (ram_rd_en) begin
          m_next_rd++;
          m_out++;
        end
        if (hs) begin
          m_out--;
          if (m_next_idx == NS - 1) m_busy = 1'b0;
          m_next_idx++;
        end
        if (fft_done && !was_busy && mode == FGYRUS_NORMAL) begin
          m_busy     = 1'b1;
          m_next_idx = 0;
          m_next_rd  = 0;
          m_out      = 0;
        end
      end
    end
  end

  task automatic pulse_done();
    fft_done = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (n_hs < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 3000) chk("wait_hs_timeout", n_hs, n);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("wait_idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, smpl_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_en"}, ram_rd_en, 0);
    chk({tag, "_rd_addr"}, ram_rd_addr, 0);
    chk({tag, "_last"}, smpl_last, 0);
    chk({tag, "_ovrn"}, ovrn, 0);
    chk({tag, "_smpl"}, smpl, 0);
    chk({tag, "_idx"}, smpl_idx, 0);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NS; i++) mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    rst      = 1'b1;
    mode     = FGYRUS_NORMAL;
    fft_done = 1'b0;
    for (int i = 0; i < NS; i++) begin
      mem[i].re = i;
      mem[i].im = -i;
    end
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Streaming with ready held high: latency, back-to-back beats, busy drop.
    n_hs = 0;
    pulse_done();
    lat = 1;
    @(negedge clk);
    while (!smpl_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, 4);
    for (int k = 0; k < NS; k++) begin
      chk("stream_valid", smpl_valid, 1);
      if (k == 5) chk("sample5_literal", smpl, {32'd5, 32'hFFFF_FFFB});
      if (k == NS - 1) chk("stream_last", smpl_last, 1);
      @(negedge clk);
    end
    chk("busy_after_last", busy, 0);
    chk("stream_count", n_hs, NS);
    chk("addr1", addr_log[1], EXP_A1);
    chk("addr2", addr_log[2], EXP_A2);
    @(posedge clk);
    #1;

    // Random backpressure.
    rand_mem();
    bp_en = 1'b1;
    n_hs  = 0;
    pulse_done();
    wait_idle();
    chk("bp_count", n_hs, NS);
    bp_en = 1'b0;

    // Overrun: second fft_done mid-frame.
    rand_mem();
    n_hs = 0;
    pulse_done();
    wait_hs(50);
    pulse_done();
    wait_idle();
    chk("ovrn_literal", ovrn, 1);
    chk("ovrn_count", n_hs, NS);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("no_restart", busy, 0);
    @(posedge clk);
    #1;

    // Abort after 60 samples.
    n_hs     = 0;
    saw_last = 1'b0;
    pulse_done();
    wait_hs(60);
    mode = FGYRUS_CONFIG;
    @(negedge clk);
    @(negedge clk);
    chk("abort_valid", smpl_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovrn", ovrn, 0);
    chk("abort_no_last", saw_last, 0);
    @(posedge clk);
    #1;
    pulse_done();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_in_config_ignored", busy, 0);
    @(posedge clk);
    #1 mode = FGYRUS_NORMAL;
    @(posedge clk);
    #1;
    n_hs = 0;
    pulse_done();
    wait_idle();
    chk("post_abort_count", n_hs, NS);

    // Reset while draining.
    n_hs = 0;
    pulse_done();
    wait_hs(125);
    ready_cmd = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    @(posedge clk);
    #1 ready_cmd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_hs = 0;
    pulse_done();
    wait_idle();
    chk("post_reset_count", n_hs, NS);

    // Random frames with backpressure.
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_mem();
      n_hs = 0;
      pulse_done();
      wait_idle();
      chk("rand_frame_count", n_hs, NS);
    end
    bp_en = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
